// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the ARM-style datapath.
// Owns NZCV, arbitrates the shared memory port and turns decoder levels into per-phase pulses.
module multicycle_sequencer #(
    parameter logic [3:0]  NZCV_RESET = 4'b0000,
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec_reg_write,
    input  logic       dec_mem_to_reg,
    input  logic       dec_mem_write,
    input  logic       dec_pc_src,
    input  logic       dec_update_nzcv,
    input  logic       dec_link,
    input  logic [3:0] alu_nzcv,
    input  logic       mem_ready,
    input  logic       halt_req,
    output logic [3:0] nzcv_q,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       fault,
    output logic [2:0] state
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(WAIT_LIMIT);
    localparam bit LIMIT_EN          = (WAIT_LIMIT != 0);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6,
        S_RESET  = 3'd7
    } state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic pc_src;
        logic update_nzcv;
        logic link;
    } ctl_t;

    state_e           state_q, state_d;
    ctl_t             ctl_q, ctl_d;
    logic [3:0]       nzcv_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_c;
    state_e           boundary_c;

    // Every instruction boundary diverts to HALT while a halt is requested.
    assign boundary_c = halt_req ? S_HALT : S_FETCH;
    assign timeout_c  = LIMIT_EN && (state_q == S_FETCH || state_q == S_MEM) && !mem_ready
                        && (({1'b0, wait_cnt_q} + (CNT_W+1)'(1)) == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl_q      <= '0;
            nzcv_q     <= NZCV_RESET;
            fault_q    <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            ctl_q      <= ctl_d;
            nzcv_q     <= nzcv_d;
            fault_q    <= fault_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctl_d      = ctl_q;
        nzcv_d     = nzcv_q;
        fault_d    = fault_q;
        wait_cnt_d = '0;
        case (state_q)
            S_RESET:  state_d = boundary_c;
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (timeout_c) state_d = S_FAULT;
            end
            S_DECODE: begin
                ctl_d.reg_write   = dec_reg_write;
                ctl_d.mem_to_reg  = dec_mem_to_reg;
                ctl_d.mem_write   = dec_mem_write;
                ctl_d.pc_src      = dec_pc_src;
                ctl_d.update_nzcv = dec_update_nzcv;
                ctl_d.link        = dec_link;
                state_d           = S_EXEC;
            end
            S_EXEC: begin
                if (ctl_q.update_nzcv) nzcv_d = alu_nzcv;
                if (ctl_q.pc_src)          state_d = boundary_c;
                else if (ctl_q.mem_to_reg) state_d = S_MEM;
                else if (ctl_q.reg_write)  state_d = S_WB;
                else                       state_d = boundary_c;
            end
            S_MEM: begin
                if (mem_ready)      state_d = ctl_q.mem_write ? boundary_c : S_WB;
                else if (timeout_c) state_d = S_FAULT;
            end
            S_WB:     state_d = boundary_c;
            S_HALT:   if (!halt_req) state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
        endcase
        if (timeout_c) fault_d = 1'b1;
        // Count stalled request cycles; the counter is zero whenever a request phase starts.
        if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 2'b00;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            S_EXEC: begin
                if (ctl_q.pc_src) begin
                    pc_we  = 1'b1;
                    pc_sel = 1'b1;
                    if (ctl_q.link) begin
                        rf_we  = 1'b1;
                        wb_sel = 2'b10;
                    end
                end
                retire = ctl_q.pc_src || !(ctl_q.mem_to_reg || ctl_q.reg_write);
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = ctl_q.mem_write;
                retire       = mem_ready && ctl_q.mem_write;
            end
            S_WB: begin
                rf_we  = 1'b1;
                wb_sel = ctl_q.mem_to_reg ? 2'b01 : 2'b00;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault = fault_q;
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: instruction-level reference model expands each instruction
// into its expected per-cycle phase trace and compares every cycle.
module tb_multicycle_sequencer;

    localparam logic [3:0]  NZCV_RST = 4'b1010;
    localparam int unsigned WLIM     = 4;

    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3,
                           WB = 3'd4, HALT = 3'd5, FAULTST = 3'd6, RESET = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dec_reg_write = 1'b0, dec_mem_to_reg = 1'b0, dec_mem_write = 1'b0;
    logic       dec_pc_src = 1'b0, dec_update_nzcv = 1'b0, dec_link = 1'b0;
    logic [3:0] alu_nzcv = 4'd0;
    logic       mem_ready = 1'b0, halt_req = 1'b0;
    logic [3:0] nzcv_q;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, retire, fault;
    logic [1:0] wb_sel;
    logic [2:0] state;

    multicycle_sequencer #(.NZCV_RESET(NZCV_RST), .WAIT_LIMIT(WLIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_reg_write(dec_reg_write), .dec_mem_to_reg(dec_mem_to_reg),
        .dec_mem_write(dec_mem_write), .dec_pc_src(dec_pc_src),
        .dec_update_nzcv(dec_update_nzcv), .dec_link(dec_link),
        .alu_nzcv(alu_nzcv), .mem_ready(mem_ready), .halt_req(halt_req),
        .nzcv_q(nzcv_q), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .retire(retire), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    // {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel, retire}
    typedef logic [12:0] out_t;

    int         npass = 0;
    int         ntotal = 0;
    logic [3:0] exp_nzcv = NZCV_RST;
    logic       exp_fault = 1'b0;
    logic [3:0] last_alu = 4'd0;
    logic [5:0] cur_dec = 6'd0;

    function automatic out_t mk(input logic [2:0] st, input logic req, we, asel, irwe,
                                pcwe, pcsel, rfwe, input logic [1:0] wbs, input logic ret);
        return {st, req, we, asel, irwe, pcwe, pcsel, rfwe, wbs, ret};
    endfunction

    function automatic out_t idle(input logic [2:0] st);
        return {st, 10'd0};
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic check(input out_t e, input string tag);
        logic [17:0] obs, ex;
        obs = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel,
               retire, nzcv_q, fault};
        ex  = {e, exp_nzcv, exp_fault};
        ntotal = ntotal + 1;
        assert (obs === ex) npass = npass + 1;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, ex);
    endtask

    // One cycle: drive inputs after the falling edge, then compare settled outputs.
    task automatic step(input out_t e, input logic rdy, input logic hlt, input logic drv,
                        input string tag);
        @(negedge clk);
        mem_ready = rdy;
        halt_req  = hlt;
        {dec_reg_write, dec_mem_to_reg, dec_mem_write, dec_pc_src, dec_update_nzcv, dec_link}
            = drv ? cur_dec : 6'($urandom);
        alu_nzcv  = 4'($urandom);
        last_alu  = alu_nzcv;
        #1;
        check(e, tag);
    endtask

    task automatic do_reset(input logic hlt);
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = rbit();
        halt_req  = rbit();
        @(negedge clk);
        exp_nzcv  = NZCV_RST;
        exp_fault = 1'b0;
        #1;
        check(idle(RESET), "reset_state");
        rst_n    = 1'b1;
        halt_req = hlt;
        #1;
        check(idle(RESET), "reset_release");
        if (hlt) step(idle(HALT), rbit(), 1'b0, 1'b0, "reset_to_halt");
    endtask

    // Reference model: expand one instruction into its phase sequence.
    task automatic run_instr(input logic rw, m2r, mw, pc, upd, lnk,
                             input int fw, input int dw, input logic hend);
        logic is_mem, is_load, is_wb, exit_exec;
        int   nh;
        cur_dec   = {rw, m2r, mw, pc, upd, lnk};
        is_mem    = !pc && m2r;
        is_load   = is_mem && !mw;
        is_wb     = !pc && !m2r && rw;
        exit_exec = !(is_mem || is_wb);
        for (int i = 0; i < fw; i++)
            step(mk(FETCH, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0), 1'b0, rbit(), 1'b0, "fetch_wait");
        step(mk(FETCH, 1, 0, 0, 1, 1, 0, 0, 2'b00, 0), 1'b1, rbit(), 1'b0, "fetch_done");
        step(idle(DECODE), rbit(), rbit(), 1'b1, "decode");
        step(mk(EXEC, 0, 0, 0, 0, pc, pc, pc && lnk, (pc && lnk) ? 2'b10 : 2'b00, exit_exec),
             rbit(), exit_exec ? hend : rbit(), 1'b0, "exec");
        if (upd) exp_nzcv = last_alu;
        if (is_mem) begin
            for (int i = 0; i < dw; i++)
                step(mk(MEM, 1, mw, 1, 0, 0, 0, 0, 2'b00, 0), 1'b0, rbit(), 1'b0, "mem_wait");
            step(mk(MEM, 1, mw, 1, 0, 0, 0, 0, 2'b00, mw), 1'b1,
                 is_load ? rbit() : hend, 1'b0, "mem_done");
        end
        if (is_load || is_wb)
            step(mk(WB, 0, 0, 0, 0, 0, 0, 1, is_load ? 2'b01 : 2'b00, 1), rbit(), hend, 1'b0,
                 "wb");
        if (hend) begin
            nh = int'($urandom_range(1, 3));
            for (int i = 0; i < nh; i++) step(idle(HALT), rbit(), 1'b1, 1'b0, "halt_hold");
            step(idle(HALT), rbit(), 1'b0, 1'b0, "halt_exit");
        end
    endtask

    initial begin
        do_reset(1'b0);
        // Directed: ALU with S, load with waits, store, BL, condition-failed, halt after WB.
        run_instr(1, 0, 0, 0, 1, 0, 0, 0, 1'b0);
        run_instr(1, 1, 0, 0, 0, 0, 2, 1, 1'b0);
        run_instr(0, 1, 1, 0, 0, 0, 0, 0, 1'b0);
        run_instr(1, 0, 0, 1, 0, 1, 0, 0, 1'b0);
        run_instr(0, 0, 0, 0, 0, 0, 1, 0, 1'b0);
        run_instr(1, 0, 0, 0, 1, 0, 0, 0, 1'b1);
        run_instr(0, 1, 1, 0, 1, 0, 3, 3, 1'b1);
        do_reset(1'b1);
        for (int n = 0; n < 150; n++)
            run_instr(rbit(), rbit(), rbit(), rbit(), rbit(), rbit(),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 4) == 0));
        // Reset while a fetch request is outstanding.
        step(mk(FETCH, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0), 1'b0, rbit(), 1'b0, "fetch_wait");
        do_reset(1'b0);
        // Memory timeout: WLIM stalled cycles, then FAULT until reset.
        for (int i = 0; i < int'(WLIM); i++)
            step(mk(FETCH, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0), 1'b0, rbit(), 1'b0, "fetch_stall");
        exp_fault = 1'b1;
        for (int i = 0; i < 3; i++) step(idle(FAULTST), 1'b1, rbit(), 1'b0, "fault_sticky");
        do_reset(1'b0);
        run_instr(1, 1, 0, 0, 1, 0, 1, 2, 1'b0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
